// File: rtl/sprite_mover_if.sv
// Sprite mover control/status bundle: direction, step, hold and load requests in; position and tick pulses out.
// The master side drives requests; the slave side (the mover) owns the registered position and pulses.
interface sprite_mover_if #(
    parameter int X_WIDTH = 8,
    parameter int Y_WIDTH = 7
);
    logic               iForwardX;
    logic               iBackX;
    logic               iForwardY;
    logic               iBackY;
    logic [2:0]         iStep;
    logic               iHold;
    logic               iLoad;
    logic [X_WIDTH-1:0] iLoadX;
    logic [Y_WIDTH-1:0] iLoadY;
    logic [X_WIDTH-1:0] oX;
    logic [Y_WIDTH-1:0] oY;
    logic               oFrameTick;
    logic               oMoveTick;
    logic               oHitEdge;

    modport master (
        output iForwardX, iBackX, iForwardY, iBackY, iStep, iHold, iLoad, iLoadX, iLoadY,
        input  oX, oY, oFrameTick, oMoveTick, oHitEdge
    );

    modport slave (
        input  iForwardX, iBackX, iForwardY, iBackY, iStep, iHold, iLoad, iLoadX, iLoadY,
        output oX, oY, oFrameTick, oMoveTick, oHitEdge
    );
endinterface

// File: rtl/sprite_mover.sv
// Steps a clamped sprite position once every MOVE_DIV frame ticks; position and pulses appear 1 cycle after the event edge.
// No backpressure: requests are sampled only on the move-event edge, a held event is dropped, load applies on any edge.
module sprite_mover #(
    parameter int X_WIDTH  = 8,
    parameter int Y_WIDTH  = 7,
    parameter int X_MAX    = 159,
    parameter int Y_MAX    = 119,
    parameter int X_INIT   = 5,
    parameter int Y_INIT   = 5,
    parameter int TICK_DIV = 833333,
    parameter int MOVE_DIV = 60
) (
    input  logic          iClock,
    input  logic          iReset,
    sprite_mover_if.slave bus
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [TW-1:0]      TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [MW-1:0]      MOVE_LAST = MW'(MOVE_DIV - 1);
    localparam logic [X_WIDTH-1:0] X_MAX_N   = X_WIDTH'(X_MAX);
    localparam logic [Y_WIDTH-1:0] Y_MAX_N   = Y_WIDTH'(Y_MAX);
    localparam logic [X_WIDTH:0]   X_MAX_W   = (X_WIDTH + 1)'(X_MAX);
    localparam logic [Y_WIDTH:0]   Y_MAX_W   = (Y_WIDTH + 1)'(Y_MAX);

    logic [TW-1:0]      frameCnt;
    logic [MW-1:0]      moveCnt;
    logic               frameEvt;
    logic               moveEvt;
    logic [X_WIDTH-1:0] stepX;
    logic [Y_WIDTH-1:0] stepY;
    logic [X_WIDTH:0]   sumX;
    logic [Y_WIDTH:0]   sumY;
    logic [X_WIDTH-1:0] nextX;
    logic [Y_WIDTH-1:0] nextY;
    logic [X_WIDTH-1:0] loadX;
    logic [Y_WIDTH-1:0] loadY;
    logic               hitX;
    logic               hitY;

    assign frameEvt = (frameCnt == TICK_LAST);
    assign moveEvt  = frameEvt && (moveCnt == MOVE_LAST);
    assign loadX    = (bus.iLoadX > X_MAX_N) ? X_MAX_N : bus.iLoadX;
    assign loadY    = (bus.iLoadY > Y_MAX_N) ? Y_MAX_N : bus.iLoadY;

    // The extra sum bit catches overshoot past MAX before it could wrap.
    always_comb begin
        stepX = X_WIDTH'(bus.iStep);
        sumX  = {1'b0, bus.oX} + {1'b0, stepX};
        nextX = bus.oX;
        hitX  = 1'b0;
        if (bus.iForwardX && !bus.iBackX) begin
            if (sumX > X_MAX_W) begin
                nextX = X_MAX_N;
                hitX  = 1'b1;
            end else begin
                nextX = sumX[X_WIDTH-1:0];
            end
        end else if (bus.iBackX && !bus.iForwardX) begin
            if (bus.oX < stepX) begin
                nextX = '0;
                hitX  = 1'b1;
            end else begin
                nextX = bus.oX - stepX;
            end
        end
    end

    always_comb begin
        stepY = Y_WIDTH'(bus.iStep);
        sumY  = {1'b0, bus.oY} + {1'b0, stepY};
        nextY = bus.oY;
        hitY  = 1'b0;
        if (bus.iForwardY && !bus.iBackY) begin
            if (sumY > Y_MAX_W) begin
                nextY = Y_MAX_N;
                hitY  = 1'b1;
            end else begin
                nextY = sumY[Y_WIDTH-1:0];
            end
        end else if (bus.iBackY && !bus.iForwardY) begin
            if (bus.oY < stepY) begin
                nextY = '0;
                hitY  = 1'b1;
            end else begin
                nextY = bus.oY - stepY;
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            frameCnt       <= '0;
            moveCnt        <= '0;
            bus.oX         <= X_WIDTH'(X_INIT);
            bus.oY         <= Y_WIDTH'(Y_INIT);
            bus.oFrameTick <= 1'b0;
            bus.oMoveTick  <= 1'b0;
            bus.oHitEdge   <= 1'b0;
        end else begin
            frameCnt       <= frameEvt ? '0 : frameCnt + TW'(1);
            if (frameEvt) begin
                moveCnt <= (moveCnt == MOVE_LAST) ? '0 : moveCnt + MW'(1);
            end
            bus.oFrameTick <= frameEvt;
            bus.oMoveTick  <= moveEvt;
            bus.oHitEdge   <= moveEvt && !bus.iLoad && !bus.iHold && (hitX || hitY);
            // Load wins over motion and hold; a held move event is simply lost.
            if (bus.iLoad) begin
                bus.oX <= loadX;
                bus.oY <= loadY;
            end else if (moveEvt && !bus.iHold) begin
                bus.oX <= nextX;
                bus.oY <= nextY;
            end
        end
    end
endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover with short tick dividers: an integer reference model checked every cycle, plus directed scenarios.
module tb_sprite_mover;
    localparam int TICK = 4;
    localparam int MOVE = 2;
    localparam int XMAX = 159;
    localparam int YMAX = 119;

    logic iClock = 1'b0;
    logic iReset = 1'b1;
    always #5 iClock = ~iClock;

    sprite_mover_if #(.X_WIDTH(8), .Y_WIDTH(7)) b ();

    sprite_mover #(
        .X_WIDTH(8), .Y_WIDTH(7), .X_MAX(XMAX), .Y_MAX(YMAX),
        .X_INIT(5), .Y_INIT(5), .TICK_DIV(TICK), .MOVE_DIV(MOVE)
    ) dut (
        .iClock(iClock),
        .iReset(iReset),
        .bus(b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: edge count since reset release, position as plain integers.
    int k = 0;
    int mX = 5, mY = 5;
    bit mFT = 0, mMT = 0, mHit = 0;
    bit modelValid = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge iClock) begin
        int t, s;
        if (iReset) begin
            k = 0; mX = 5; mY = 5; mFT = 0; mMT = 0; mHit = 0;
            modelValid = 1;
        end else begin
            k++;
            mFT  = (k % TICK == 0);
            mMT  = (k % (TICK * MOVE) == 0);
            mHit = 0;
            s    = int'(b.iStep);
            if (b.iLoad) begin
                mX = (int'(b.iLoadX) > XMAX) ? XMAX : int'(b.iLoadX);
                mY = (int'(b.iLoadY) > YMAX) ? YMAX : int'(b.iLoadY);
            end else if (mMT && !b.iHold) begin
                if (b.iForwardX != b.iBackX) begin
                    t = b.iForwardX ? mX + s : mX - s;
                    if (t > XMAX) begin t = XMAX; mHit = 1; end
                    if (t < 0)    begin t = 0;    mHit = 1; end
                    mX = t;
                end
                if (b.iForwardY != b.iBackY) begin
                    t = b.iForwardY ? mY + s : mY - s;
                    if (t > YMAX) begin t = YMAX; mHit = 1; end
                    if (t < 0)    begin t = 0;    mHit = 1; end
                    mY = t;
                end
            end
        end
    end

    always @(negedge iClock) begin
        if (modelValid) begin
            check("model oX", b.oX, mX);
            check("model oY", b.oY, mY);
            check("model oFrameTick", b.oFrameTick, mFT);
            check("model oMoveTick", b.oMoveTick, mMT);
            check("model oHitEdge", b.oHitEdge, mHit);
        end
    end

    task automatic clearInputs();
        b.iForwardX = 0; b.iBackX = 0; b.iForwardY = 0; b.iBackY = 0;
        b.iStep = 3'd0; b.iHold = 0; b.iLoad = 0; b.iLoadX = '0; b.iLoadY = '0;
    endtask

    task automatic doReset();
        clearInputs();
        iReset = 1'b1;
        repeat (2) @(negedge iClock);
        check("reset oX", b.oX, 5);
        check("reset oY", b.oY, 5);
        check("reset pulses", {b.oFrameTick, b.oMoveTick, b.oHitEdge}, 0);
        iReset = 1'b0;
    endtask

    task automatic goEdge(input int n);
        for (int g = 0; g < 500 && k < n; g++) @(negedge iClock);
        check("edge reached", k, n);
    endtask

    task automatic setDirs(input bit fx, input bit bx, input bit fy, input bit by, input int step);
        b.iForwardX = fx; b.iBackX = bx; b.iForwardY = fy; b.iBackY = by;
        b.iStep = 3'(step);
    endtask

    typedef struct {
        bit fx, bx, fy, by;
        int step;
        bit hold;
        int ex, ey, eh;
    } vec_t;
    vec_t vecs[9];

    initial begin
        clearInputs();
        vecs[0] = '{1, 0, 0, 0, 1, 0, 159, 1, 0};
        vecs[1] = '{1, 0, 0, 0, 2, 0, 159, 1, 1};
        vecs[2] = '{0, 0, 0, 1, 0, 0, 159, 1, 0};
        vecs[3] = '{0, 0, 0, 1, 1, 0, 159, 0, 0};
        vecs[4] = '{0, 0, 0, 1, 7, 0, 159, 0, 1};
        vecs[5] = '{0, 1, 0, 0, 7, 1, 159, 0, 0};
        vecs[6] = '{0, 1, 0, 0, 7, 0, 152, 0, 0};
        vecs[7] = '{1, 0, 1, 1, 7, 0, 159, 0, 0};
        vecs[8] = '{0, 1, 1, 0, 5, 0, 154, 5, 0};

        // Idle run: tick cadence, position untouched.
        doReset();
        goEdge(3);  check("idle ft edge3", b.oFrameTick, 0);
        goEdge(4);  check("idle ft edge4", b.oFrameTick, 1);
                    check("idle mt edge4", b.oMoveTick, 0);
        goEdge(8);  check("idle mt edge8", b.oMoveTick, 1);
        goEdge(16); check("idle mt edge16", b.oMoveTick, 1);
                    check("idle x", b.oX, 5);

        // Forward X by 3 twice.
        doReset();
        setDirs(1, 0, 0, 0, 3);
        goEdge(7);  check("fwd x before event", b.oX, 5);
        goEdge(8);  check("fwd x edge8", b.oX, 8);
        goEdge(16); check("fwd x edge16", b.oX, 11);
                    check("fwd y", b.oY, 5);
                    check("fwd hit", b.oHitEdge, 0);

        // Load then saturate both axes, twice.
        doReset();
        b.iLoad = 1; b.iLoadX = 8'd157; b.iLoadY = 7'd2;
        goEdge(1);  b.iLoad = 0;
        check("load x", b.oX, 157);
        check("load y", b.oY, 2);
        setDirs(1, 0, 0, 1, 4);
        goEdge(8);  check("sat x", b.oX, 159); check("sat y", b.oY, 0); check("sat hit", b.oHitEdge, 1);
        goEdge(16); check("sat2 x", b.oX, 159); check("sat2 y", b.oY, 0); check("sat2 hit", b.oHitEdge, 1);

        // Opposing X cancels, Y advances; then hold swallows the next event.
        doReset();
        setDirs(1, 1, 1, 0, 1);
        goEdge(8);  check("cancel x", b.oX, 5); check("cancel y", b.oY, 6);
        b.iHold = 1;
        goEdge(16); check("hold x", b.oX, 5); check("hold y", b.oY, 6);
                    check("hold mt", b.oMoveTick, 1); check("hold hit", b.oHitEdge, 0);

        // Load coincident with a move event wins and clamps.
        doReset();
        setDirs(1, 0, 0, 0, 1);
        goEdge(7);
        b.iLoad = 1; b.iLoadX = 8'd200; b.iLoadY = 7'd100;
        goEdge(8);  check("ldmove x", b.oX, 159); check("ldmove y", b.oY, 100);
                    check("ldmove mt", b.oMoveTick, 1); check("ldmove hit", b.oHitEdge, 0);
        b.iLoad = 0;

        // Reset mid-frame restarts the tick phase.
        doReset();
        b.iLoad = 1; b.iLoadX = 8'd20; b.iLoadY = 7'd20;
        goEdge(1);  b.iLoad = 0;
        goEdge(5);  check("pre-reset x", b.oX, 20);
        iReset = 1'b1;
        @(negedge iClock);
        check("midreset x", b.oX, 5); check("midreset y", b.oY, 5);
        check("midreset pulses", {b.oFrameTick, b.oMoveTick, b.oHitEdge}, 0);
        iReset = 1'b0;
        goEdge(3);  check("post-reset ft edge3", b.oFrameTick, 0);
        goEdge(4);  check("post-reset ft edge4", b.oFrameTick, 1);

        // Vector table; junk on the direction inputs between events must not matter.
        doReset();
        b.iLoad = 1; b.iLoadX = 8'd158; b.iLoadY = 7'd1;
        goEdge(1);  b.iLoad = 0;
        for (int j = 1; j <= 9; j++) begin
            goEdge(8 * j - 6);
            setDirs(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7));
            b.iHold = 1'($urandom_range(0, 1));
            goEdge(8 * j - 3);
            setDirs(vecs[j-1].fx, vecs[j-1].bx, vecs[j-1].fy, vecs[j-1].by, vecs[j-1].step);
            b.iHold = vecs[j-1].hold;
            goEdge(8 * j);
            check($sformatf("vec%0d x", j), b.oX, vecs[j-1].ex);
            check($sformatf("vec%0d y", j), b.oY, vecs[j-1].ey);
            check($sformatf("vec%0d hit", j), b.oHitEdge, vecs[j-1].eh);
            check($sformatf("vec%0d mt", j), b.oMoveTick, 1);
        end

        @(negedge iClock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_mover.md
SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 Parameter X_WIDTH, 8, width of X coordinate.
REQ-002 Parameter Y_WIDTH, 7, width of Y coordinate.
REQ-003 Parameter X_MAX, 159, largest legal X.
REQ-004 Parameter Y_MAX, 119, largest legal Y.
REQ-005 Parameter X_INIT, 5, X after reset.
REQ-006 Parameter Y_INIT, 5, Y after reset.
REQ-007 Parameter TICK_DIV, 833333, iClock cycles per frame tick (50 MHz to 60 Hz).
REQ-008 Parameter MOVE_DIV, 60, frame ticks per move event.
REQ-009 Legal parameters: TICK_DIV >= 2, MOVE_DIV >= 1, X_INIT <= X_MAX, Y_INIT <= Y_MAX, X_MAX < 2^X_WIDTH, Y_MAX < 2^Y_WIDTH.
REQ-010 iClock  in  1  sole clock; all state changes on its rising edge.
REQ-011 iReset  in  1  synchronous, active-high reset.
REQ-012 iForwardX, iBackX  in  1 each  request +X / -X motion.
REQ-013 iForwardY, iBackY  in  1 each  request +Y / -Y motion.
REQ-014 iStep  in  3  pixels moved per move event; 0 means no motion.
REQ-015 iHold  in  1  suppress position update; counters keep running.
REQ-016 iLoad  in  1  synchronous position load strobe.
REQ-017 iLoadX  in  X_WIDTH  X value for load; iLoadY  in  Y_WIDTH  Y value for load.
REQ-018 oX  out  X_WIDTH  registered X; oY  out  Y_WIDTH  registered Y.
REQ-019 oFrameTick  out  1  one-cycle registered pulse per frame.
REQ-020 oMoveTick  out  1  one-cycle registered pulse per move event.
REQ-021 oHitEdge  out  1  one-cycle pulse: a requested move was clamped at a bound.

Function
REQ-022 Frame counter SHALL count 0..TICK_DIV-1 and wrap to 0; on the edge where it equals TICK_DIV-1, oFrameTick SHALL be set to 1 for exactly the following cycle.
REQ-023 Move counter SHALL advance only on frame events, counting 0..MOVE_DIV-1 and wrapping; a frame event with move counter = MOVE_DIV-1 is a move event.
REQ-024 On a move event edge, oMoveTick SHALL be set to 1 for the following cycle, and oX/oY SHALL show the updated position in that same cycle (latency 1 cycle from event edge).
REQ-025 Direction inputs and iStep SHALL be sampled only on the move event edge; their values between events SHALL have no effect.
REQ-026 Per axis: forward only -> +iStep; back only -> -iStep; both or neither -> no change on that axis.
REQ-027 Arithmetic SHALL use one extra bit; forward result > MAX SHALL saturate to MAX; back with coordinate < iStep SHALL saturate to 0; no wrap-around.
REQ-028 oHitEdge SHALL pulse with oMoveTick when either axis saturated, including a request made while already at the bound; iStep = 0 SHALL never raise it.
REQ-029 iHold = 1 on a move event SHALL leave oX/oY unchanged and oHitEdge low; oMoveTick still pulses; the event is consumed, not deferred.
REQ-030 iLoad = 1 SHALL on that edge set oX = min(iLoadX, X_MAX), oY = min(iLoadY, Y_MAX), regardless of tick phase.
REQ-031 iLoad SHALL take priority over motion and iHold on a coincident move event; oMoveTick still pulses, oHitEdge stays low.
REQ-032 iLoad SHALL NOT alter either counter.

Reset
REQ-033 iReset = 1 at an edge SHALL set both counters to 0, oX = X_INIT, oY = Y_INIT, and oFrameTick, oMoveTick, oHitEdge to 0 from the next cycle.
REQ-034 iReset SHALL override iLoad and any coincident tick or move event.
REQ-035 After reset is released, the first oFrameTick SHALL follow the TICK_DIV-th rising edge with iReset = 0.

Verification (TICK_DIV=4, MOVE_DIV=2, X_MAX=159, Y_MAX=119, init 5,5)
REQ-036 Release reset, no inputs -> oFrameTick high after edges 4, 8, 12, 16; oMoveTick high after edges 8, 16; oX=5, oY=5 throughout.
REQ-037 iForwardX=1, iStep=3, run two move events -> oX=8 after edge 8, oX=11 after edge 16; oY=5; oHitEdge low.
REQ-038 Load (157,2), then iForwardX=1, iBackY=1, iStep=4 -> next move event gives oX=159, oY=0 with oHitEdge=1; the following event gives 159,0 with oHitEdge=1.
REQ-039 iForwardX=iBackX=1, iForwardY=1, iStep=1 -> X unchanged, Y+1; iHold=1 on the next event -> no change, oMoveTick=1, oHitEdge=0.
REQ-040 iLoad with (200,100) on a move event edge with iForwardX=1 -> oX=159, oY=100, oMoveTick=1, oHitEdge=0.
REQ-041 Assert iReset at edge 6 mid-frame with position 20,20 -> next cycle oX=5, oY=5, pulses low; next oFrameTick 4 edges after release.
